// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory arbiter and the IF stage.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } own_t;

    // addi x0,x0,0; the IF stage issues it while a fetch is stalled or killed.
    localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of data grants taken while a fetch was waiting.
module arb_starve_ctr #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_,
    input  logic inc,
    input  logic clr,
    output logic force_if
);

    localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

    logic [3:0] cnt;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_)
            cnt <= 4'd0;
        else if (clr)
            cnt <= 4'd0;
        else if (inc && cnt < CNT_MAX)
            cnt <= cnt + 4'd1;
    end

    assign force_if = (cnt >= CNT_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port, 1-cycle-latency memory between fetch and data
// ports; data wins unless fetch has been starved STARVE_MAX times in a row.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              flush,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_wstrb,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [31:0]       d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    logic force_if;
    logic if_ok;
    own_t resp_own;
    logic resp_we;

    // Grants are held low while reset is asserted so every output reads 0.
    assign if_ok  = rst_ & if_req & ~flush;
    assign if_gnt = if_ok & (~d_req | force_if);
    assign d_gnt  = rst_ & d_req & ~(if_ok & force_if);

    arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
        .clk      (clk),
        .rst_     (rst_),
        .inc      (d_gnt & if_req & ~flush),
        .clr      (if_gnt | ~if_req),
        .force_if (force_if)
    );

    always_comb begin
        mem_req   = d_gnt | if_gnt;
        mem_we    = 1'b0;
        mem_wstrb = 4'b0;
        mem_addr  = '0;
        mem_wdata = 32'b0;
        if (d_gnt) begin
            mem_we    = d_we;
            mem_wstrb = d_we ? d_wstrb : 4'b0;
            mem_addr  = d_addr[ADDR_W+1:2];
            mem_wdata = d_wdata;
        end else if (if_gnt) begin
            mem_addr  = if_addr[ADDR_W+1:2];
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            resp_own <= OWN_NONE;
            resp_we  <= 1'b0;
        end else begin
            resp_own <= d_gnt ? OWN_D : (if_gnt ? OWN_IF : OWN_NONE);
            resp_we  <= d_gnt & d_we;
        end
    end

    // A flush in the response cycle only squashes the fetch valid.
    assign if_valid = (resp_own == OWN_IF) & ~flush;
    assign if_rdata = (resp_own == OWN_IF) ? mem_rdata : 32'b0;
    assign d_valid  = (resp_own == OWN_D);
    assign d_rdata  = (resp_own == OWN_D && !resp_we) ? mem_rdata : 32'b0;

    // Byte-offset and wrap-around address bits are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                                d_addr[31:ADDR_W+2], d_addr[1:0]};

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Shares one single-port, 1-cycle-latency synchronous memory between the IF-stage fetch port and the MEM-stage load/store port.
- Sits between the pipeline and the unified memory, replacing the dedicated instruction memory path.
- Data port normally wins; a starvation counter guarantees fetch progress.
- Each response is routed back to the port that issued it, and a fetch response is suppressed on pipeline flush.

## Interface
- ADDR_W, 10, memory word-address width (memory depth 2^ADDR_W words)
- STARVE_MAX, 4, consecutive data grants with fetch pending before fetch is forced (1..15)
- clk  in  1  clock; all state updates on posedge clk
- rst_  in  1  asynchronous, active-low reset
- flush  in  1  pipeline flush/redirect from EX; kills fetch grant and fetch response this cycle
- if_req  in  1  fetch request
- if_addr  in  32  fetch byte address
- if_gnt  out  1  fetch request accepted this cycle (combinational)
- if_valid  out  1  fetch response valid
- if_rdata  out  32  fetch data
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_wstrb  in  4  byte-write enables (stores only)
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_gnt  out  1  data request accepted this cycle (combinational)
- d_valid  out  1  data response (load data or store ack)
- d_rdata  out  32  load data; 0 for store acks
- mem_req, mem_we  out  1  memory strobe and write enable
- mem_wstrb  out  4  memory byte enables
- mem_addr  out  ADDR_W  word address = selected addr[ADDR_W+1:2]; upper bits ignored (wrap)
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data, valid the cycle after mem_req

## Operation
- At most one grant per cycle. mem_req = if_gnt | d_gnt; memory signals are muxed from the granted port, else driven 0.
- Priority, d_req and if_req both high:
  - d_gnt if starve_cnt < STARVE_MAX, otherwise if_gnt.
  - A single requester is always granted, subject to the flush rule below.
- flush=1 → if_gnt=0, even if only if_req is high. The data port is unaffected.
- starve_cnt (4 bits):
  - Increments when d_gnt=1 and if_req=1 and not flush.
  - Clears on if_gnt, or when if_req=0.
  - Saturates at STARVE_MAX.
- Owner register: resp_own ∈ {NONE, IF, D}, with resp_we. Loaded each cycle from the grant: NONE if no grant.
- Responses, cycle after grant:
  - resp_own=IF → if_valid = ~flush, if_rdata = mem_rdata.
  - resp_own=D → d_valid=1; d_rdata = resp_we ? 0 : mem_rdata.
  - A non-owning port's valid is 0 and its rdata is 0.
- Low-order address bits [1:0] are ignored. Alignment checking is the requester's job.
- Reset asserted mid-transaction: resp_own→NONE, starve_cnt→0, and the in-flight response is discarded (no valid after reset release).

## Timing
- Grant: combinational, same cycle as request. Requester must hold address/data only in the request cycle.
- Response latency: exactly 1 cycle after grant. Back-to-back grants give one response per cycle, fully pipelined.
- Reset values: all outputs 0, resp_own=NONE, starve_cnt=0.
- Flush in the response cycle of a fetch kills if_valid in that cycle only. Flush in the grant cycle prevents the grant.
- Simultaneous d_req, if_req and flush: data granted, starve_cnt unchanged.

## Structure
- Shared package `mem_arb_pkg`:
  - owner encoding OWN_NONE=2'd0, OWN_IF=2'd1, OWN_D=2'd2
  - NOP constant 32'h00000013, reused by the IF stage
- Sub-module `arb_starve_ctr`: the saturating counter with inc/clr/saturate and a `force_if` output.
- Grant logic, muxing and owner register live in the top.

## Test plan
- Reset with d_req=if_req=1 held → all outputs 0. After release, d_gnt=1 first cycle; d_valid=1 next cycle.
- Lone fetch, if_addr=0x0000_0010, mem word 4 = 0x0050_0093 → mem_addr=4, if_gnt=1; next cycle if_valid=1, if_rdata=0x0050_0093.
- Store then load:
  - Store: d_we=1, d_wstrb=4'b0011, d_addr=0x20, d_wdata=0xAABB_CCDD over prior 0x1122_3344 → ack with d_rdata=0.
  - Load from 0x20 → d_rdata=0x1122_CCDD.
- Both ports requesting continuously, STARVE_MAX=4 → grant pattern D,D,D,D,IF repeating, responses correctly routed.
- Fetch granted, flush=1 in response cycle → if_valid=0. flush=1 with lone if_req → if_gnt=0, mem_req=0.
- Reset asserted in the cycle after a load grant → no d_valid is ever produced for that load.
